// File: rtl/stencil_pkg.sv
// Shared defaults, types and tap indexing for the 3x3 stencil window generator.
package stencil_pkg;

    localparam int DATA_W   = 32;
    localparam int COL_SIZE = 64;
    localparam int ROW_SIZE = 128;
    localparam int WIN_TAPS = 9;

    typedef logic [DATA_W-1:0] pix_t;

    // Flat tap index of a window element: k1 is the row offset, k2 the column offset.
    function automatic int tap(input int k1, input int k2);
        return k1 * 3 + k2;
    endfunction

endpackage

// File: rtl/stencil_line_buf.sv
// One row of pixel history: single-port RAM with combinational read-before-write.
module stencil_line_buf #(
    parameter int DATA_W = stencil_pkg::DATA_W,
    parameter int DEPTH  = stencil_pkg::COL_SIZE,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The read sees the old contents; the write lands at the clock edge.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/stencil_window_gen.sv
// Streams row-major pixels in and emits one 3x3 neighbourhood per interior position.
// Define STENCIL_WIN_COORD_EN to add the out_row/out_col top-left coordinate outputs.
module stencil_window_gen #(
    parameter int DATA_W   = stencil_pkg::DATA_W,
    parameter int COL_SIZE = stencil_pkg::COL_SIZE,
    parameter int ROW_SIZE = stencil_pkg::ROW_SIZE
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [DATA_W-1:0]                        in_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [stencil_pkg::WIN_TAPS*DATA_W-1:0]  out_win,
    output logic                                     out_last
`ifdef STENCIL_WIN_COORD_EN
    ,
    output logic [$clog2(ROW_SIZE)-1:0]              out_row,
    output logic [$clog2(COL_SIZE)-1:0]              out_col
`endif
);

    import stencil_pkg::*;

    localparam int CW = $clog2(COL_SIZE);
    localparam int RW = $clog2(ROW_SIZE);

    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic          accept;
    logic          emit;
    logic          col_wrap;
    logic          row_wrap;

    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] col_new [3];
    logic [DATA_W-1:0] hist_p0 [3][2];
    logic [WIN_TAPS*DATA_W-1:0] win_next;

    logic                       vld_p1;
    logic [WIN_TAPS*DATA_W-1:0] win_p1;
    logic                       last_p1;
`ifdef STENCIL_WIN_COORD_EN
    logic [RW-1:0] row_p1;
    logic [CW-1:0] col_p1;
`endif

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_wrap = (in_col == CW'(COL_SIZE - 1));
    assign row_wrap = (in_row == RW'(ROW_SIZE - 1));
    assign emit     = (in_row >= RW'(2)) && (in_col >= CW'(2));

    // lb1 holds row r-1 and shifts its old content down into lb0 (row r-2).
    stencil_line_buf #(.DATA_W(DATA_W), .DEPTH(COL_SIZE), .AW(CW)) u_lb0 (
        .clk   (clk),
        .addr  (in_col),
        .we    (accept),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    stencil_line_buf #(.DATA_W(DATA_W), .DEPTH(COL_SIZE), .AW(CW)) u_lb1 (
        .clk   (clk),
        .addr  (in_col),
        .we    (accept),
        .wdata (in_data),
        .rdata (lb1_rd)
    );

    always_comb begin
        col_new[0] = lb0_rd;
        col_new[1] = lb1_rd;
        col_new[2] = in_data;
        win_next   = '0;
        for (int k1 = 0; k1 < 3; k1++) begin
            win_next[tap(k1, 0)*DATA_W +: DATA_W] = hist_p0[k1][0];
            win_next[tap(k1, 1)*DATA_W +: DATA_W] = hist_p0[k1][1];
            win_next[tap(k1, 2)*DATA_W +: DATA_W] = col_new[k1];
        end
    end

    // Stage p0: the two most recent columns; at c = 2 both come from the current row.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k1 = 0; k1 < 3; k1++) begin
                hist_p0[k1][0] <= hist_p0[k1][1];
                hist_p0[k1][1] <= col_new[k1];
            end
        end
    end

    // Stage p1: position counters and the held output window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_col  <= '0;
            in_row  <= '0;
            vld_p1  <= 1'b0;
            win_p1  <= '0;
            last_p1 <= 1'b0;
`ifdef STENCIL_WIN_COORD_EN
            row_p1  <= '0;
            col_p1  <= '0;
`endif
        end else begin
            if (accept) begin
                if (col_wrap) begin
                    in_col <= '0;
                    in_row <= row_wrap ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
                vld_p1 <= emit;
                if (emit) begin
                    win_p1  <= win_next;
                    last_p1 <= row_wrap && col_wrap;
`ifdef STENCIL_WIN_COORD_EN
                    row_p1  <= in_row - RW'(2);
                    col_p1  <= in_col - CW'(2);
`endif
                end
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_win   = win_p1;
    assign out_last  = last_p1;
`ifdef STENCIL_WIN_COORD_EN
    assign out_row   = row_p1;
    assign out_col   = col_p1;
`endif

endmodule

// File: tb/tb_stencil_window_gen.sv
// Scoreboard bench: a 4x4 instance for directed scenarios and a default-size instance for random traffic.
module tb_stencil_window_gen;

    localparam int W  = 32;
    localparam int SC = 4;
    localparam int SR = 4;
    localparam int BC = 64;
    localparam int BR = 128;

    typedef struct packed {
        logic [9*W-1:0] win;
        logic           last;
        logic [7:0]     row;
        logic [7:0]     col;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
    logic [W-1:0]   s_in_data;
    logic [9*W-1:0] s_out_win;
    logic           b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [W-1:0]   b_in_data;
    logic [9*W-1:0] b_out_win;
`ifdef STENCIL_WIN_COORD_EN
    logic [1:0] s_out_row, s_out_col;
    logic [6:0] b_out_row;
    logic [5:0] b_out_col;
`endif

    stencil_window_gen #(.DATA_W(W), .COL_SIZE(SC), .ROW_SIZE(SR)) u_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_win(s_out_win), .out_last(s_out_last)
`ifdef STENCIL_WIN_COORD_EN
        , .out_row(s_out_row), .out_col(s_out_col)
`endif
    );

    stencil_window_gen u_big (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_win(b_out_win), .out_last(b_out_last)
`ifdef STENCIL_WIN_COORD_EN
        , .out_row(b_out_row), .out_col(b_out_col)
`endif
    );

    int checks = 0;
    int failures = 0;
    exp_t q_s[$];
    exp_t q_b[$];
    logic [9*W-1:0] log_s[$];
    int   pops_b = 0;
    logic b_last_seen = 1'b0;
    logic b_done = 1'b0;
    logic [W-1:0] img [2][BR][BC];
    int   pos_r [2];
    int   pos_c [2];

    task automatic check(input string name, input logic [9*W-1:0] act, input logic [9*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Window with top-left value base in a 4-wide image whose pixel is base + r*4 + c.
    function automatic logic [9*W-1:0] mk(input int base);
        logic [9*W-1:0] v;
        v = '0;
        for (int k1 = 0; k1 < 3; k1++)
            for (int k2 = 0; k2 < 3; k2++)
                v[(k1*3+k2)*W +: W] = W'(base + k1*4 + k2);
        return v;
    endfunction

    // Reference: record the pixel and, for interior positions, extract the 3x3 block ending here.
    task automatic model(input int inst, input logic [W-1:0] d);
        int rows, cols, r, c;
        exp_t e;
        rows = (inst == 0) ? SR : BR;
        cols = (inst == 0) ? SC : BC;
        r = pos_r[inst];
        c = pos_c[inst];
        img[inst][r][c] = d;
        if (r >= 2 && c >= 2) begin
            e = '0;
            for (int k1 = 0; k1 < 3; k1++)
                for (int k2 = 0; k2 < 3; k2++)
                    e.win[(k1*3+k2)*W +: W] = img[inst][r-2+k1][c-2+k2];
            e.last = (r == rows-1) && (c == cols-1);
            e.row  = 8'(r-2);
            e.col  = 8'(c-2);
            if (inst == 0) q_s.push_back(e);
            else           q_b.push_back(e);
        end
        c++;
        if (c == cols) begin
            c = 0;
            r++;
            if (r == rows) r = 0;
        end
        pos_r[inst] = r;
        pos_c[inst] = c;
    endtask

    task automatic pop_exp(input int inst, output exp_t e, output logic have);
        have = 1'b0;
        e = '0;
        if (inst == 0) begin
            if (q_s.size() > 0) begin e = q_s.pop_front(); have = 1'b1; end
        end else begin
            if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
        end
        check("window_expected", 288'(have), 288'(1));
    endtask

    // Monitor: every handshaken window is popped against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic have;
        if (s_rst && s_out_valid && s_out_ready) begin
            log_s.push_back(s_out_win);
            pop_exp(0, e, have);
            if (have) begin
                check("small_win", s_out_win, e.win);
                check("small_last", 288'(s_out_last), 288'(e.last));
`ifdef STENCIL_WIN_COORD_EN
                check("small_row", 288'(s_out_row), 288'(e.row));
                check("small_col", 288'(s_out_col), 288'(e.col));
`endif
            end
        end
        if (b_rst && b_out_valid && b_out_ready) begin
            pops_b++;
            b_last_seen = b_out_last;
            pop_exp(1, e, have);
            if (have) begin
                check("big_win", b_out_win, e.win);
                check("big_last", 288'(b_out_last), 288'(e.last));
`ifdef STENCIL_WIN_COORD_EN
                check("big_row", 288'(b_out_row), 288'(e.row));
                check("big_col", 288'(b_out_col), 288'(e.col));
`endif
            end
        end
    end

    logic           s_prev_stall = 1'b0;
    logic [9*W-1:0] s_prev_win = '0;
    always @(negedge clk) begin
        if (s_rst && s_prev_stall) begin
            check("stall_valid_held", 288'(s_out_valid), 288'(1));
            check("stall_win_held", s_out_win, s_prev_win);
        end
        if (s_rst && s_out_valid && !s_out_ready)
            check("stall_in_ready", 288'(s_in_ready), 288'(0));
        s_prev_stall = s_rst && s_out_valid && !s_out_ready;
        s_prev_win   = s_out_win;
    end

    task automatic send_s(input logic [W-1:0] d);
        logic acc;
        int n;
        n = 0;
        acc = 1'b0;
        s_in_valid = 1'b1;
        s_in_data  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_in_ready;
            if (acc) model(0, d);
            @(posedge clk);
            #1;
            n++;
        end
        check("small_send_timeout", 288'(acc), 288'(1));
        s_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [W-1:0] d);
        logic acc;
        int n;
        n = 0;
        acc = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = b_in_ready;
            if (acc) model(1, d);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("big_send_timeout", 288'(acc), 288'(1));
        b_in_valid = 1'b0;
    endtask

    task automatic frame_s(input int base);
        for (int r = 0; r < SR; r++)
            for (int c = 0; c < SC; c++)
                send_s(W'(base + r*SC + c));
    endtask

    task automatic drain_s();
        int n;
        n = 0;
        while (q_s.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("small_drain", 288'(q_s.size()), 288'(0));
        @(posedge clk);
        #1;
    endtask

    // Directed 4x4 sequence: windows at top-left (0,0),(0,1),(1,0),(1,1).
    task automatic check_log(input string name, input int first, input int base);
        for (int i = 0; i < 4; i++)
            check(name, log_s[first+i], mk(base + (i/2)*4 + (i%2)));
    endtask

    initial begin
        s_rst = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
        b_rst = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        pos_r[0] = 0; pos_c[0] = 0; pos_r[1] = 0; pos_c[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 288'(s_out_valid), 288'(0));
        check("reset_out_win", s_out_win, 288'(0));
        s_rst = 1'b1;
        b_rst = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", 288'(s_out_valid), 288'(0));
        check("post_reset_out_last", 288'(s_out_last), 288'(0));
        check("post_reset_in_ready", 288'(s_in_ready), 288'(1));
        check("post_reset_big_in_ready", 288'(b_in_ready), 288'(1));
        @(posedge clk);
        #1;

        // Single frame at full throughput.
        log_s.delete();
        frame_s(0);
        drain_s();
        check("s1_count", 288'(log_s.size()), 288'(4));
        if (log_s.size() == 4) check_log("s1_win", 0, 0);

        // Output stall right after the first window.
        log_s.delete();
        fork
            frame_s(0);
            begin
                int n;
                n = 0;
                while (!s_out_valid && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                s_out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                s_out_ready = 1'b1;
            end
        join
        drain_s();
        check("s2_count", 288'(log_s.size()), 288'(4));
        if (log_s.size() == 4) check_log("s2_win", 0, 0);

        // Back-to-back frames; frame 2 must not see frame 1 data.
        log_s.delete();
        frame_s(0);
        frame_s(100);
        drain_s();
        check("s3_count", 288'(log_s.size()), 288'(8));
        if (log_s.size() == 8) begin
            check_log("s3_win_f1", 0, 0);
            check_log("s3_win_f2", 4, 100);
        end

        // Reset right after pixel (2,3) while its window is pending.
        log_s.delete();
        for (int i = 0; i < 12; i++) send_s(W'(i));
        s_rst = 1'b0;
        void'(q_s.pop_back());
        pos_r[0] = 0;
        pos_c[0] = 0;
        #1;
        check("s4_reset_out_valid", 288'(s_out_valid), 288'(0));
        check("s4_reset_out_win", s_out_win, 288'(0));
        repeat (2) @(posedge clk);
        #1;
        s_rst = 1'b1;
        log_s.delete();
        frame_s(0);
        drain_s();
        check("s4_count", 288'(log_s.size()), 288'(4));
        if (log_s.size() == 4) check_log("s4_win", 0, 0);

        // Default-size frame with random input gaps and output back-pressure.
        fork
            begin
                for (int r = 0; r < BR; r++)
                    for (int c = 0; c < BC; c++) begin
                        int gap;
                        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                        repeat (gap) begin
                            @(posedge clk);
                            #1;
                        end
                        send_b($urandom);
                    end
                b_done = 1'b1;
            end
            begin
                while (!b_done) begin
                    @(posedge clk);
                    #1;
                    b_out_ready = ($urandom_range(0, 3) != 0);
                end
                b_out_ready = 1'b1;
            end
        join
        begin
            int n;
            n = 0;
            while (q_b.size() != 0 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("s5_drain", 288'(q_b.size()), 288'(0));
        check("s5_count", 288'(pops_b), 288'(7812));
        check("s5_last", 288'(b_last_seen), 288'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stencil_window_gen.md
# stencil_window_gen

Upstream feeder for the 2D stencil compute stage. Accepts a row-major pixel stream over a valid/ready handshake and buffers the two previous rows in line buffers. Emits one complete 3x3 neighbourhood per interior output position, so the stencil stage can multiply-accumulate a whole window per beat instead of re-reading `orig`. Output windows are indexed by their top-left pixel (r, c), matching the stencil's `sol[r*col_size + c]` addressing.

## Interface
- `DATA_W`, 32: pixel width in bits
- `COL_SIZE`, 64: pixels per row
- `ROW_SIZE`, 128: rows per frame
- `clk` input 1: clock
- `rst` input 1: reset, asynchronous, active-low
- `in_valid` input 1: input pixel valid
- `in_ready` output 1: block can accept a pixel this cycle
- `in_data` input DATA_W: pixel, row-major order
- `out_valid` output 1: window valid
- `out_ready` input 1: downstream accepts the window
- `out_win` output 9*DATA_W: tap k1*3+k2 at bits [(k1*3+k2)*DATA_W +: DATA_W]; k1 is row offset, k2 is column offset from the top-left pixel
- `out_last` output 1: last window of the frame
- `out_row` output $clog2(ROW_SIZE): window top-left row. Present only with `STENCIL_WIN_COORD_EN`.
- `out_col` output $clog2(COL_SIZE): window top-left column. Present only with `STENCIL_WIN_COORD_EN`.

## Operation
- Input counters `in_row` and `in_col` track the position of the next pixel. They advance on every input accept (`in_valid && in_ready`). `in_col` wraps at COL_SIZE-1 and increments `in_row`; `in_row` wraps at ROW_SIZE-1 to 0, which starts the next frame.
- Two line buffers, each COL_SIZE x DATA_W:
  - `lb1` holds row r-1; `lb0` holds row r-2.
  - On accept at column c: read `lb0[c]` and `lb1[c]`, write `lb0[c] <= lb1[c]` and `lb1[c] <= in_data`.
- 3x3 shift window: on accept, columns shift left by one. The new right column is {`lb0[c]`, `lb1[c]`, `in_data`} from top to bottom.
- Emit condition: an accept at (r, c) with r >= 2 and c >= 2 loads the output register with the window whose top-left is (r-2, c-2).
  - Accepts with r < 2 or c < 2 update the buffers only.
  - Residue from the previous row is flushed before c = 2, so there is no cross-row contamination.
- `out_last` is set when the accepted pixel is (ROW_SIZE-1, COL_SIZE-1).
- Windows per frame: (ROW_SIZE-2)*(COL_SIZE-2). The default is 7812.
- Line buffer contents are not reset. They are never observable, because rows 0 and 1 emit nothing.

## Timing
- Reset values: `out_valid`=0, `out_win`=0, `out_last`=0, `out_row`/`out_col`=0, all counters 0. `in_ready`=1 while reset is deasserted and `out_valid`=0.
- `in_ready = !out_valid || out_ready`. This is combinational, with no dependency on `in_valid`.
- Latency: an accept in cycle N gives `out_valid`=1 in cycle N+1.
- Throughput: one pixel per cycle when `out_ready` is held high.
- `out_valid`, `out_win`, `out_last` and the coordinates are held stable while `out_valid && !out_ready`. No input is accepted during that stall.
- Simultaneous pop and push (`out_valid && out_ready` and an input accept in the same cycle): the register reloads if the new pixel emits. Otherwise `out_valid` drops to 0.
- Reset asserted mid-frame: the pending window is dropped, the counters clear, and the first pixel after release is treated as (0, 0).

## Configuration
- `STENCIL_WIN_COORD_EN` defined: `out_row` and `out_col` ports exist and are registered alongside `out_win`.
- Not defined: those ports and their registers are absent. Behaviour is otherwise identical.

## Structure
- Package `stencil_pkg`:
  - `DATA_W`, `COL_SIZE`, `ROW_SIZE` defaults
  - `WIN_TAPS`=9
  - `pix_t` typedef
  - tap-index function `tap(k1,k2)=k1*3+k2`
- Sub-module `stencil_line_buf`: a single-port read-before-write RAM, COL_SIZE x DATA_W, instantiated twice.

## Test plan
1. COL_SIZE=4, ROW_SIZE=4, pixel = r*4+c, `out_ready`=1 → first window arrives one cycle after pixel (2,2) is accepted, with taps {0,1,2,4,5,6,8,9,10}. Exactly 4 windows are produced; the last is {5,6,7,9,10,11,13,14,15} with `out_last`=1.
2. Same stream with `out_ready`=0 for 5 cycles after the first `out_valid` → `in_ready`=0, `out_win` is held, and no pixels are lost. The window sequence is unchanged.
3. Two back-to-back frames, second frame pixel = 100+r*4+c → the first window of frame 2 is {100,101,102,104,105,106,108,109,110}. No frame-1 data leaks into it.
4. Reset pulsed after pixel (2,3) of frame 1, then a fresh frame → `out_valid` is 0 during reset. Output after reset matches scenario 1 exactly.
5. Default parameters, random `in_valid` and `out_ready` gaps → 7812 windows. Each matches a software 3x3 extraction of `orig`.
6. `STENCIL_WIN_COORD_EN` defined with scenario 1 stimulus → `out_row`/`out_col` sequence is (0,0), (0,1), (1,0), (1,1).
